// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - shared types and constants for the fp_12 request dispatcher
package fp_pkg;

  typedef logic [31:0] fp32_t;

  localparam logic [7:0] FP_EXP_MAX = 8'hFF;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } disp_state_t;

endpackage

// File: rtl/fp_req_fifo.sv
// rtl/fp_req_fifo.sv - request queue; full/empty come from the registered count only
module fp_req_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_wr_tvalid,
  input  logic [W-1:0] i_wr_tdata,
  output logic         o_wr_tready,
  output logic         o_rd_tvalid,
  output logic [W-1:0] o_rd_tdata,
  input  logic         i_rd_tready
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_push;
  logic          w_pop;

  assign o_wr_tready = (r_count != (AW+1)'(DEPTH));
  assign o_rd_tvalid = (r_count != '0);
  assign o_rd_tdata  = r_mem[r_rd_ptr];
  assign w_push      = i_wr_tvalid && o_wr_tready;
  assign w_pop       = i_rd_tready && o_rd_tvalid;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_wr_tdata;
    end
  end

  // Pointers wrap for free because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/fp_dispatch.sv
// rtl/fp_dispatch.sv - queues add/sub requests, issues them in order to fp_12 and returns tagged results
// Optional macro FP_DISPATCH_EXC_EN enables the Inf/NaN exception flag on res_exc.
module fp_dispatch
  import fp_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int FPU_LAT = 2,
  parameter int TAG_W   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [31:0]      req_a,
  input  logic [31:0]      req_b,
  input  logic             req_op,
  input  logic [TAG_W-1:0] req_tag,
  output logic [31:0]      fpu_a,
  output logic [31:0]      fpu_b,
  output logic             fpu_op,
  input  logic [31:0]      fpu_c,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [31:0]      res_c,
  output logic [TAG_W-1:0] res_tag,
  output logic             res_exc,
  output logic             busy
);

  localparam int FW    = 65 + TAG_W;
  localparam int CNT_W = (FPU_LAT > 1) ? $clog2(FPU_LAT) : 1;

  disp_state_t      r_state;
  disp_state_t      w_state_nxt;
  logic             r_rdy_en;
  logic [CNT_W-1:0] r_cnt;
  fp32_t            r_fpu_a;
  fp32_t            r_fpu_b;
  logic             r_fpu_op;
  logic [TAG_W-1:0] r_tag_if;
  fp32_t            r_res_c;
  logic [TAG_W-1:0] r_res_tag;

  logic             w_fifo_ready;
  logic             w_fifo_valid;
  logic [FW-1:0]    w_fifo_tdata;
  fp32_t            w_head_a;
  fp32_t            w_head_b;
  logic             w_head_op;
  logic [TAG_W-1:0] w_head_tag;
  logic             w_pop;
  logic             w_capture;

  fp_req_fifo #(
    .DEPTH (DEPTH),
    .W     (FW)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst),
    .i_wr_tvalid (req_valid && r_rdy_en),
    .i_wr_tdata  ({req_a, req_b, req_op, req_tag}),
    .o_wr_tready (w_fifo_ready),
    .o_rd_tvalid (w_fifo_valid),
    .o_rd_tdata  (w_fifo_tdata),
    .i_rd_tready (w_pop)
  );

  assign {w_head_a, w_head_b, w_head_op, w_head_tag} = w_fifo_tdata;

  // r_rdy_en keeps req_ready low while reset is held, even though the FIFO reads empty.
  assign req_ready = r_rdy_en && w_fifo_ready;
  assign busy      = (r_state != IDLE) || w_fifo_valid;
  assign res_valid = (r_state == RESP);
  assign w_capture = (r_state == WAIT) && (r_cnt == '0);
  assign fpu_a     = r_fpu_a;
  assign fpu_b     = r_fpu_b;
  assign fpu_op    = r_fpu_op;
  assign res_c     = r_res_c;
  assign res_tag   = r_res_tag;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_fifo_valid) begin
          w_pop       = 1'b1;
          w_state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (r_cnt == '0) w_state_nxt = RESP;
      end
      RESP: begin
        if (res_ready) begin
          if (w_fifo_valid) begin
            w_pop       = 1'b1;
            w_state_nxt = WAIT;
          end else begin
            w_state_nxt = IDLE;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rdy_en  <= 1'b0;
      r_cnt     <= '0;
      r_fpu_a   <= '0;
      r_fpu_b   <= '0;
      r_fpu_op  <= 1'b0;
      r_tag_if  <= '0;
      r_res_c   <= '0;
      r_res_tag <= '0;
    end else begin
      r_rdy_en <= 1'b1;
      if (w_pop) begin
        r_fpu_a  <= w_head_a;
        r_fpu_b  <= w_head_b;
        r_fpu_op <= w_head_op;
        r_tag_if <= w_head_tag;
        r_cnt    <= CNT_W'(FPU_LAT - 1);
      end else if ((r_state == WAIT) && (r_cnt != '0)) begin
        r_cnt <= r_cnt - 1'b1;
      end
      if (w_capture) begin
        r_res_c   <= fpu_c;
        r_res_tag <= r_tag_if;
      end
    end
  end

`ifdef FP_DISPATCH_EXC_EN
  logic r_res_exc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_res_exc <= 1'b0;
    end else if (w_capture) begin
      r_res_exc <= (fpu_c[30:23] == FP_EXP_MAX);
    end
  end

  assign res_exc = r_res_exc;
`else
  assign res_exc = 1'b0;
`endif

endmodule

// File: doc/fp_dispatch.md
FP_DISPATCH -- requirements
Module: fp_dispatch

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning request FIFO entries (power of 2, >=2).
REQ-002 SHALL have parameter FPU_LAT, default 2, meaning cycles operands are held before fpu_c is sampled (>=1).
REQ-003 SHALL have parameter TAG_W, default 4, meaning request/result tag width.
REQ-004 SHALL have port clk  in  1  sole clock, all state on rising edge.
REQ-005 SHALL have port rst  in  1  reset; one clock, reset asynchronous and active-low.
REQ-006 SHALL have ports req_valid in 1 / req_ready out 1, meaning request handshake.
REQ-007 SHALL have ports req_a in 32 / req_b in 32, meaning IEEE-754 single operands.
REQ-008 SHALL have port req_op in 1, meaning 0 = add, 1 = subtract.
REQ-009 SHALL have port req_tag in TAG_W, meaning an opaque ID returned with the result.
REQ-010 SHALL have ports fpu_a out 32 / fpu_b out 32 / fpu_op out 1, which drive the fp_12 a/b/op inputs.
REQ-011 SHALL have port fpu_c in 32, connected to the fp_12 c output.
REQ-012 SHALL have ports res_valid out 1 / res_ready in 1, meaning result handshake.
REQ-013 SHALL have ports res_c out 32 / res_tag out TAG_W / res_exc out 1, meaning result, tag and exception flag.
REQ-014 SHALL have port busy out 1, high when the FSM is not IDLE or the FIFO is not empty.

Function
REQ-015 SHALL push {a,b,op,tag} into the FIFO on req_valid&&req_ready; req_ready = !full, derived from registered count only.
REQ-016 SHALL keep FIFO pointers wrapping modulo DEPTH, and the count in range 0..DEPTH.
REQ-017 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-018 In IDLE with FIFO non-empty, SHALL pop the head at edge N, register it onto fpu_a/b/op, load the counter with FPU_LAT-1, and enter WAIT.
REQ-019 In WAIT, SHALL hold fpu_* stable and decrement the counter; at counter==0, SHALL capture fpu_c into res_c, capture the tag into res_tag, and enter RESP.
REQ-020 SHALL assert res_valid exactly in RESP; first assertion is cycle N+FPU_LAT+1 after the pop edge N.
REQ-021 In RESP, SHALL hold res_c/res_tag/res_exc stable until res_ready.
REQ-022 On res_ready in RESP, SHALL pop the next entry and go directly to WAIT if the FIFO is non-empty, else go to IDLE (no bubble).
REQ-023 On simultaneous push and pop, SHALL leave count unchanged; a push into an empty FIFO is not poppable in the same cycle.
REQ-024 SHALL keep fpu_* holding the last issued operands while in IDLE.
REQ-025 SHALL issue and return results strictly in order of acceptance.

Reset
REQ-026 On rst low, SHALL asynchronously clear: FSM to IDLE, FIFO pointers/count 0, counter 0, fpu_a/fpu_b 0, fpu_op 0, res_c 0, res_tag 0, res_exc 0, res_valid 0.
REQ-027 During reset, SHALL drive req_ready 0 and busy 0.
REQ-028 After reset, SHALL drive req_ready 1 from the first edge after deassertion.
REQ-029 Reset asserted mid-operation SHALL discard all queued and in-flight requests, with no result emitted.

Configuration
REQ-030 With macro FP_DISPATCH_EXC_EN defined, res_exc SHALL be captured with res_c, set to 1 when fpu_c[30:23]==8'hFF (Inf/NaN).
REQ-031 Without FP_DISPATCH_EXC_EN, res_exc SHALL be tied 0 and no exponent-detect logic SHALL exist; the port SHALL remain present.

Structure
REQ-032 Package fp_pkg SHALL hold: fp32_t typedef; the FP_EXP_MAX=8'hFF constant; OP_ADD/OP_SUB constants; the dispatch state enum.
REQ-033 The FIFO SHALL be a sub-module fp_req_fifo (parameterised DEPTH and width); the FSM, counter and result registers SHALL live in fp_dispatch.

Verification
REQ-034 Scenario: a=0x41900000, b=0x41880000, op=0, tag=1 -> res_c=0x420C0000, res_tag=1, res_valid at cycle N+FPU_LAT+1.
REQ-035 Scenario: same operands, op=1, tag=2 -> res_c=0x3F800000; a=0xBF800000, b=0xBF800000, op=0 -> res_c=0xC0000000.
REQ-036 Scenario: res_ready held 0, push 5 requests with DEPTH=4 -> req_ready drops after 4 FIFO pushes plus 1 in flight.
REQ-036 (cont.) Scenario: then release res_ready -> results return in order with tags 0..4 and no bubble cycles.
REQ-037 Scenario: fpu_c model returns 0x7F800000 -> res_exc=1 with FP_DISPATCH_EXC_EN defined, res_exc=0 without it.
REQ-038 Scenario: rst pulsed low in WAIT with 2 entries queued -> res_valid 0 immediately, busy 0, and no stale result after release.
